ex_mem_stage_reg: RTL and testbench
===================================

# ex_mem_stage_reg

Parametrised EX/MEM pipeline stage register with a valid/ready handshake, synchronous flush and an optional skid entry. It sits between the execute stage (ALU, branch-target adder, destination-register mux) and the memory stage. Compared with a plain clock-edge latch, it adds back-pressure, bubble insertion, reset and a resolved branch-taken output.

## Interface
- DATA_W, 32, width of branch target, ALU result and store data
- REG_AW, 5, destination register index width
- WB_W, 2, write-back control field width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held and incoming entries
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- ctlwb_out  in  WB_W  write-back control
- ctlm_out  in  3  memory control: [2] memread, [1] memwrite, [0] branch
- adder_out  in  DATA_W  branch target
- aluzero  in  1  ALU zero flag
- aluout  in  DATA_W  ALU result
- readdat2  in  DATA_W  store data
- muxout  in  REG_AW  destination register
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM stage consumes this cycle
- wb_ctlout  out  WB_W  registered write-back control
- memread, memwrite, branch  out  1 each  registered memory control bits
- add_result, alu_result, rdata2out  out  DATA_W each  registered datapath fields
- zero  out  1  registered ALU zero flag
- five_bit_muxout  out  REG_AW  registered destination register
- pcsrc  out  1  branch taken: out_valid & branch & zero (combinational from registers)

## Operation
- Accept: in_valid && in_ready. Transfer: out_valid && out_ready.
- Main entry drives the outputs. On transfer without a new accept, the main entry empties.
- When the main entry is empty, or is transferring, an accepted input loads the main entry.
- Skid entry (EXMEM_SKID_EN only): an accept while the main entry is full and not transferring loads the skid entry. When the main entry transfers and the skid entry is full, skid moves to main. in_ready = !skid_valid, which is registered.
- Control-bit gating: when an entry is empty, its wb/memread/memwrite/branch bits are 0, so an empty slot is a true bubble. Datapath fields may retain stale values.
- flush takes priority over all else. It clears both valid bits and zeroes all control bits, and drops any input presented in the same cycle. in_ready is unaffected by flush.
- Reset values: out_valid=0, in_ready=1, all control outputs 0, all datapath outputs 0, pcsrc=0, skid empty.
- A reset mid-transfer discards everything. The first accept is possible in the first cycle after deassertion.

## Timing
- Latency: input accepted at edge N appears on the outputs after edge N.
- Throughput: one instruction per cycle while out_ready=1.
- With EXMEM_SKID_EN, in_ready has no combinational path from out_ready, and one extra entry is absorbed after back-pressure starts.
- Without the macro, in_ready = !out_valid || out_ready, which is a combinational path.
- Simultaneous accept and transfer on a full main entry: the new data replaces the old, and out_valid stays 1.
- in_valid must stay high with stable payload until accepted. Once out_valid is high, it drops only after a transfer, a flush or a reset.

## Configuration
- EXMEM_SKID_EN defined: two-entry stage (main plus skid), with in_ready registered.
- EXMEM_SKID_EN undefined: one-entry stage, with in_ready combinational as described under Timing. Port list is identical in both builds.

## Structure
- Package ex_mem_pkg holds:
  - typedef ex_mem_payload_t: a packed struct of all input fields
  - the M-control bit index constants MC_MEMREAD=2, MC_MEMWRITE=1, MC_BRANCH=0
  - WB_W and M_W=3
- One sub-module is natural: pipe_skid_reg, a generic payload register with valid/ready, flush and a `ifdef`'d skid entry. ex_mem_stage_reg packs and unpacks the struct and derives pcsrc.

## Test plan
- Reset check: assert rst mid-stream -> all outputs 0, out_valid=0, in_ready=1 immediately. First accept occurs one cycle after rst drops.
- Streaming: out_ready=1, in_valid=1 with aluout=1..8 -> alu_result follows one cycle later, 8 transfers in 8 cycles, no bubbles.
- Back-pressure: out_ready=0 for 3 cycles while streaming.
  - With macro: in_ready falls after 2 accepts, held values are 1 and 2, and no loss or duplication after release.
  - Without macro: in_ready falls after 1 accept.
- Flush while both entries are full, with in_valid=1 in the same cycle -> next cycle out_valid=0, memwrite=0, wb_ctlout=0, and the flushed-cycle input is not seen.
- Branch: ctlm_out=3'b001, aluzero=1, adder_out=0x40 -> pcsrc=1 and add_result=0x40. Same with aluzero=0 -> pcsrc=0.
- Bubble: in_valid=0 with ctlm_out=3'b010 driven -> memwrite stays 0 and out_valid=0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage register.
// The payload struct below uses the default field widths.
package ex_mem_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int WB_W   = 2;
  localparam int M_W    = 3;

  // Bit positions inside the memory-control field
  localparam int MC_MEMREAD  = 2;
  localparam int MC_MEMWRITE = 1;
  localparam int MC_BRANCH   = 0;

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] adder;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata2;
    logic [REG_AW-1:0] rd;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready payload register with synchronous flush.
// Define EXMEM_SKID_EN for a second (skid) entry and a registered in_ready.
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Handshake: a beat moves on an edge where valid && ready; the sender holds
  // valid and data stable until then, and valid never drops without a move.
  logic         main_v;
  logic [W-1:0] main_d;
  logic         acc;
  logic         xfer;

  assign acc       = in_valid && in_ready;
  assign xfer      = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;

`ifdef EXMEM_SKID_EN
  logic         skid_v;
  logic [W-1:0] skid_d;

  assign in_ready = !skid_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      main_d <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || xfer) begin
      // Skid is only ever full while main is full, so it always drains first
      if (skid_v) begin
        main_d <= skid_d;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= acc;
        if (acc) main_d <= in_data;
      end
    end else if (acc) begin
      skid_d <= in_data;
      skid_v <= 1'b1;
    end
  end
`else
  assign in_ready = !main_v || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      main_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
    end else if (acc) begin
      main_v <= 1'b1;
      main_d <= in_data;
    end else if (xfer) begin
      main_v <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register with valid/ready, flush and branch resolve.
// Optional skid entry selected by defining EXMEM_SKID_EN.
module ex_mem_stage_reg
  import ex_mem_pkg::M_W, ex_mem_pkg::MC_MEMREAD, ex_mem_pkg::MC_MEMWRITE,
         ex_mem_pkg::MC_BRANCH;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int WB_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   ctlwb_out,
  input  logic [M_W-1:0]    ctlm_out,
  input  logic [DATA_W-1:0] adder_out,
  input  logic              aluzero,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] readdat2,
  input  logic [REG_AW-1:0] muxout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_ctlout,
  output logic              memread,
  output logic              memwrite,
  output logic              branch,
  output logic [DATA_W-1:0] add_result,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic              zero,
  output logic [REG_AW-1:0] five_bit_muxout,
  output logic              pcsrc
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [DATA_W-1:0] adder;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata2;
    logic [REG_AW-1:0] rd;
  } payload_t;

  payload_t in_p;
  payload_t q;

  assign in_p = '{wb: ctlwb_out, m: ctlm_out, adder: adder_out, zero: aluzero,
                  alu: aluout, rdata2: readdat2, rd: muxout};

  pipe_skid_reg #(.W($bits(payload_t))) u_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (q)
  );

  // Control bits are masked by valid so an empty slot is a true bubble
  assign wb_ctlout       = out_valid ? q.wb : '0;
  assign memread         = out_valid & q.m[MC_MEMREAD];
  assign memwrite        = out_valid & q.m[MC_MEMWRITE];
  assign branch          = out_valid & q.m[MC_BRANCH];
  assign add_result      = q.adder;
  assign alu_result      = q.alu;
  assign rdata2out       = q.rdata2;
  assign zero            = q.zero;
  assign five_bit_muxout = q.rd;
  assign pcsrc           = branch & q.zero;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg against a queue-based model of the stage.
// Builds with or without EXMEM_SKID_EN.
module tb_ex_mem_stage_reg;
  import ex_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WB_W-1:0]   wb_ctlout;
  logic              memread, memwrite, branch, zero, pcsrc;
  logic [DATA_W-1:0] add_result, alu_result, rdata2out;
  logic [REG_AW-1:0] five_bit_muxout;
  ex_mem_payload_t   drv_p = '0;

  ex_mem_payload_t   exp_q[$];
  int                chk_cnt = 0;
  int                err_cnt = 0;
  int                dut_acc_cnt = 0;
  int                dut_xfer_cnt = 0;
  bit                last_acc = 1'b0;
  logic [DATA_W-1:0] seq = 1;

  always #5 clk = ~clk;

  ex_mem_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctlwb_out(drv_p.wb), .ctlm_out(drv_p.m), .adder_out(drv_p.adder),
    .aluzero(drv_p.zero), .aluout(drv_p.alu), .readdat2(drv_p.rdata2),
    .muxout(drv_p.rd), .out_valid(out_valid), .out_ready(out_ready),
    .wb_ctlout(wb_ctlout), .memread(memread), .memwrite(memwrite), .branch(branch),
    .add_result(add_result), .alu_result(alu_result), .rdata2out(rdata2out),
    .zero(zero), .five_bit_muxout(five_bit_muxout), .pcsrc(pcsrc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ex_mem_payload_t rand_p();
    ex_mem_payload_t r;
    r.wb     = WB_W'($urandom_range(3, 0));
    r.m      = M_W'($urandom_range(7, 0));
    r.adder  = $urandom;
    r.zero   = 1'($urandom_range(1, 0));
    r.alu    = $urandom;
    r.rdata2 = $urandom;
    r.rd     = REG_AW'($urandom_range(31, 0));
    return r;
  endfunction

  // Readiness of the stage as described by its capacity rules
  function automatic bit model_ready();
`ifdef EXMEM_SKID_EN
    return exp_q.size() < 2;
`else
    return exp_q.size() == 0 || out_ready;
`endif
  endfunction

  task automatic check_outputs();
    bit v;
    ex_mem_payload_t h;
    v = exp_q.size() > 0;
    h = v ? exp_q[0] : '0;
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("in_ready", 64'(in_ready), 64'(model_ready()));
    chk("wb_ctlout", 64'(wb_ctlout), 64'(h.wb));
    chk("memread", 64'(memread), 64'(h.m[MC_MEMREAD]));
    chk("memwrite", 64'(memwrite), 64'(h.m[MC_MEMWRITE]));
    chk("branch", 64'(branch), 64'(h.m[MC_BRANCH]));
    chk("pcsrc", 64'(pcsrc), 64'(h.m[MC_BRANCH] && h.zero));
    if (v) begin
      chk("add_result", 64'(add_result), 64'(h.adder));
      chk("alu_result", 64'(alu_result), 64'(h.alu));
      chk("rdata2out", 64'(rdata2out), 64'(h.rdata2));
      chk("zero", 64'(zero), 64'(h.zero));
      chk("five_bit_muxout", 64'(five_bit_muxout), 64'(h.rd));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_ctl"}, 64'({wb_ctlout, memread, memwrite, branch, pcsrc}), 64'(0));
    chk({tag, "_add"}, 64'(add_result), 64'(0));
    chk({tag, "_alu"}, 64'(alu_result), 64'(0));
    chk({tag, "_rd2"}, 64'(rdata2out), 64'(0));
    chk({tag, "_zero_rd"}, 64'({zero, five_bit_muxout}), 64'(0));
  endtask

  // One clock: check at negedge, update the model at posedge, return at posedge+1
  task automatic cycle();
    bit acc, xfer;
    @(negedge clk);
    check_outputs();
    if (in_valid && in_ready) dut_acc_cnt++;
    if (out_valid && out_ready) dut_xfer_cnt++;
    acc  = in_valid && model_ready();
    xfer = exp_q.size() > 0 && out_ready;
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (xfer) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(drv_p);
    end
    last_acc = acc && !flush;
    #1;
  endtask

  // Present a fresh payload unless an offered one is still waiting to be accepted
  task automatic drive_next(input bit v);
    if (!(in_valid && !last_acc)) begin
      in_valid  = v;
      drv_p     = rand_p();
      drv_p.alu = seq;
      seq++;
    end
  endtask

  initial begin
    int base_acc, base_xfer;
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming: aluout 1..8, one per cycle
    out_ready = 1'b1;
    seq = 1;
    base_acc = dut_acc_cnt;
    base_xfer = dut_xfer_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_next(1'b1);
      cycle();
    end
    chk("stream_accepts", 64'(dut_acc_cnt - base_acc), 64'(8));
    in_valid = 1'b0;
    cycle();
    chk("stream_transfers", 64'(dut_xfer_cnt - base_xfer), 64'(8));
    cycle();

    // Back-pressure for 3 cycles, then release and drain
    seq = 1;
    out_ready = 1'b0;
    base_acc = dut_acc_cnt;
    for (int i = 0; i < 3; i++) begin
      drive_next(1'b1);
      cycle();
    end
`ifdef EXMEM_SKID_EN
    chk("bp_accepts", 64'(dut_acc_cnt - base_acc), 64'(2));
`else
    chk("bp_accepts", 64'(dut_acc_cnt - base_acc), 64'(1));
`endif
    chk("bp_head", 64'(alu_result), 64'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_next(1'b1);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Flush with the stage full and a new input offered the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_next(1'b1);
      cycle();
    end
    flush = 1'b1;
    in_valid = 1'b1;
    drv_p = rand_p();
    drv_p.m = 3'b010;
    drv_p.wb = 2'b11;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Branch resolution, taken then not taken
    in_valid = 1'b1;
    drv_p = rand_p();
    drv_p.m = 3'b001;
    drv_p.zero = 1'b1;
    drv_p.adder = 32'h40;
    cycle();
    drv_p.zero = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();

    // Bubble with memwrite control driven on an invalid input
    drv_p.m = 3'b010;
    for (int i = 0; i < 2; i++) cycle();

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(3, 0) != 0);
      flush = ($urandom_range(31, 0) == 0);
      drive_next(1'($urandom_range(1, 0)));
      cycle();
    end
    flush = 1'b0;

    // Reset in the middle of a stalled stream
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_next(1'b1);
      cycle();
    end
    #2 rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    last_acc = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    drv_p = rand_p();
    base_acc = dut_acc_cnt;
    cycle();
    chk("first_accept_after_rst", 64'(dut_acc_cnt - base_acc), 64'(1));
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
